uart_tx_fifo: RTL and testbench

Buffered UART transmitter: accepts bytes over a push handshake into an internal FIFO, then serializes each byte as an 8N1 frame (start, 8 data LSB-first, stop) on `o_tx`. Bit timing comes from the shared `baudrate` block's oversampled `baud_tick`. It is the transmit-side counterpart of `uart_rx`: byte producers (loopback path, command echo) write into it without waiting on `o_tx_busy`.

---
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : FIFO-buffered 8N1 UART transmitter paced by an oversampled tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic                  push,
    input  logic [7:0]            din,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  o_tx,
    output logic                  o_tx_busy,
    output logic                  o_tx_done
);

    localparam int c_depth  = 1 << DEPTH_LOG2;
    localparam int c_tick_w = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [c_tick_w-1:0]   c_tick_last = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [DEPTH_LOG2:0]   c_full_cnt  = (DEPTH_LOG2 + 1)'(c_depth);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]            r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    // Transmitter datapath
    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_tick_w-1:0]   r_tick_cnt;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shreg;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_stop_end;
    logic                  r_done;

    logic                  w_push_ok;
    logic                  w_pop;
    logic                  w_bit_end;
    logic                  w_tx_nxt;

    assign full      = (r_count == c_full_cnt);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign o_tx      = r_tx;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;

    assign w_push_ok = push & ~full;
    assign w_bit_end = baud_tick && (r_tick_cnt == c_tick_last) && (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_nxt = r_shreg[0];
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Chain straight into the next frame when data is waiting
                if (w_bit_end) begin
                    if (!empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Line outputs trail the state by one cycle, so done is delayed twice to
    // land in the same cycle busy drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_shreg    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_stop_end <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (r_state != S_IDLE);
            r_stop_end <= w_bit_end && (r_state == S_STOP);
            r_done     <= r_stop_end;
            if (w_pop) begin
                r_shreg    <= r_mem[r_rd_ptr];
                r_tick_cnt <= '0;
                r_bit_idx  <= '0;
            end else if ((r_state != S_IDLE) && baud_tick) begin
                r_tick_cnt <= w_bit_end ? '0 : (r_tick_cnt + c_tick_w'(1));
                if (w_bit_end && (r_state == S_DATA)) begin
                    r_shreg   <= {1'b0, r_shreg[7:1]};
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo with a UART decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int OS       = 4;
    localparam int TICK_DIV = 3;
    localparam int BIT_CLK  = OS * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       push;
    logic [7:0] din;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       o_tx;
    logic       o_tx_busy;
    logic       o_tx_done;

    int n_checks     = 0;
    int n_errors     = 0;
    int done_cnt     = 0;
    int busy_falls   = 0;
    int fall_no_done = 0;
    int stop_errs    = 0;
    logic prev_busy  = 1'b0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_tx_fifo #(
        .DEPTH_LOG2 (3),
        .OVERSAMPLE (OS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .push       (push),
        .din        (din),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .o_tx       (o_tx),
        .o_tx_busy  (o_tx_busy),
        .o_tx_done  (o_tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_tx(input logic lvl, input int max, output int n);
        n = 0;
        while (o_tx !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (o_tx_busy !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < max), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic expect_rx(input string tag);
        check({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check(tag, (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    // Tick source: one-cycle pulse every TICK_DIV clocks
    initial begin
        int div = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (div == TICK_DIV - 1) begin
                div = 0;
                baud_tick = 1'b1;
            end else begin
                div++;
                baud_tick = 1'b0;
            end
        end
    end

    // Serial decoder: samples each bit mid-way, referenced to the start edge
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (o_tx === 1'b0) begin
                repeat (BIT_CLK + BIT_CLK / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    b[k] = o_tx;
                    repeat (BIT_CLK) @(negedge clk);
                end
                if (o_tx !== 1'b1) stop_errs++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (o_tx_done === 1'b1) done_cnt++;
            if (prev_busy === 1'b1 && o_tx_busy === 1'b0) begin
                busy_falls++;
                if (o_tx_done !== 1'b1) fall_no_done++;
            end
            prev_busy = o_tx_busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_done;
        int base_falls;
        int base_nodone;
        int low_cnt;
        logic [7:0] b;

        rst  = 1'b1;
        push = 1'b0;
        din  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", o_tx, 1);
        check("rst_busy", o_tx_busy, 0);
        check("rst_done", o_tx_done, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single frame 8'h32: latency, bit length and decode
        base_done = done_cnt;
        din  = 8'h32;
        push = 1'b1;
        @(negedge clk);
        push = 1'b0;
        check("lat_count1", count, 1);
        check("lat_empty0", empty, 0);
        check("lat_busy0", o_tx_busy, 0);
        @(negedge clk);
        check("lat_popped", count, 0);
        check("lat_tx_idle", o_tx, 1);
        @(negedge clk);
        check("lat_tx_start", o_tx, 0);
        check("lat_busy1", o_tx_busy, 1);
        wait_tx(1'b1, 40, n);
        wait_tx(1'b0, 40, n);
        wait_tx(1'b1, 40, n);
        wait_tx(1'b0, 40, n);
        check("bit_len_2bits", n, 2 * BIT_CLK);
        wait_idle("f1_idle", 200);
        check("f1_done_cnt", done_cnt - base_done, 1);
        check("f1_count", count, 0);
        check("f1_busy", o_tx_busy, 0);
        exp_q.push_back(8'h32);
        expect_rx("f1_rx");

        // Four back-to-back frames
        base_done  = done_cnt;
        base_falls = busy_falls;
        exp_q = '{8'hA5, 8'h00, 8'hFF, 8'h5A};
        for (int k = 0; k < 4; k++) begin
            din  = exp_q[k];
            push = 1'b1;
            @(negedge clk);
        end
        push = 1'b0;
        wait_idle("b2b_idle", 700);
        check("b2b_done_cnt", done_cnt - base_done, 4);
        check("b2b_busy_falls", busy_falls - base_falls, 1);
        check("b2b_fall_no_done", fall_no_done, 0);
        expect_rx("b2b_rx");

        // Overfill with wrap, then push while full in the pop cycle
        base_done = done_cnt;
        for (int k = 0; k < 10; k++) begin
            din  = 8'(8'h30 + k);
            push = 1'b1;
            @(negedge clk);
            if (k == 8) begin
                check("fill_full", full, 1);
                check("fill_count", count, 8);
            end
        end
        check("drop_count", count, 8);
        din = 8'hEE;
        n = 0;
        while (count == 4'd8 && n < 400) begin
            @(negedge clk);
            n++;
        end
        push = 1'b0;
        check("pop_full_count", count, 7);
        check("pop_full_flag", full, 0);
        for (int k = 0; k < 9; k++) exp_q.push_back(8'(8'h30 + k));
        wait_idle("fill_idle", 2500);
        check("fill_done_cnt", done_cnt - base_done, 9);
        check("fill_fall_no_done", fall_no_done, 0);
        expect_rx("fill_rx");

        // Reset during data bit 4 of 8'hC3 with more bytes queued
        din = 8'hC3; push = 1'b1; @(negedge clk);
        din = 8'h11; @(negedge clk);
        din = 8'h22; @(negedge clk);
        din = 8'h33; @(negedge clk);
        push = 1'b0;
        wait_tx(1'b0, 20, n);
        repeat (64) @(negedge clk);
        check("pre_rst_tx", o_tx, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tx", o_tx, 1);
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_busy", o_tx_busy, 0);
        check("mid_rst_done", o_tx_done, 0);
        base_done   = done_cnt;
        base_nodone = fall_no_done;
        low_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (o_tx !== 1'b1) low_cnt++;
        end
        check("post_rst_line_idle", low_cnt, 0);
        check("post_rst_no_done", done_cnt - base_done, 0);
        rx_q.delete();

        // Loopback of random bytes through the decoder
        base_done = done_cnt;
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            din  = b;
            push = 1'b1;
            @(negedge clk);
        end
        push = 1'b0;
        wait_idle("loop_idle", 1500);
        check("loop_done_cnt", done_cnt - base_done, 8);
        check("loop_fall_no_done", fall_no_done - base_nodone, 0);
        check("stop_bits", stop_errs, 0);
        expect_rx("loop_rx");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
